if_fetch_stage: RTL and testbench

RV32I instruction-fetch front end: program-counter register, word-organised instruction memory with a write/preload port, and the IF/ID pipeline register. The block takes the next-PC value selected by the PC mux and fetches from the current PC. It presents the latched PC, PC+4, instruction and branch-prediction bit to the decode stage. Sits between the PC-select mux/hazard unit and the ID stage.

---
 rtl/if_fetch_stage_pkg.sv | 26 ++
 rtl/if_fetch_stage_ifid_reg.sv | 25 ++
 rtl/if_fetch_stage_imem.sv | 37 +++
 rtl/if_fetch_stage_pc_reg.sv | 22 ++
 rtl/if_fetch_stage.sv | 77 +++++++
 tb/tb_if_fetch_stage.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
// The IF/ID payload struct is the single definition used by the top and the pipeline register.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- the bubble held in IF/ID after reset or flush
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            pred;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
    ifid_t b;
    b.pc   = '0;
    b.pc4  = '0;
    b.inst = nop;
    b.pred = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register; flush wins over enable and loads a NOP bubble.
module if_fetch_stage_ifid_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = RV32I_NOP
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= ifid_bubble(NOP_INST);
    end else if (flush) begin
      q <= ifid_bubble(NOP_INST);
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_stage_imem.sv
// Word-organised instruction memory: one synchronous write port, one combinational read port.
// Byte-offset and out-of-range address bits are dropped, so addresses wrap modulo MEM_DEPTH*4.
module if_fetch_stage_imem
  import if_fetch_stage_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic [XLEN-1:0] rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic            unused_addr_bits;

  assign rd_idx  = rd_addr[AW+1:2];
  assign wr_idx  = wr_addr[AW+1:2];
  assign rd_data = mem[rd_idx];

  assign unused_addr_bits = ^{rd_addr[XLEN-1:AW+2], rd_addr[1:0],
                              wr_addr[XLEN-1:AW+2], wr_addr[1:0]};

  // No reset on the array: contents survive rst so a preloaded program is kept.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch_stage_pc_reg.sv
// Program-counter register with hazard-unit write enable.
module if_fetch_stage_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I fetch front end: PC register, instruction memory and IF/ID register.
// Only wiring and the PC+4 adder live here.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              MEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST  = RV32I_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            ifid_en,
  input  logic            ifid_flush,
  input  logic [XLEN-1:0] next_pc,
  input  logic            prediction_in,
  input  logic            wb_en,
  input  logic [XLEN-1:0] wb_address,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_pc4,
  output logic [XLEN-1:0] fetch_inst,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc4_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            prediction_out
);

  ifid_t ifid_d;
  ifid_t ifid_q;

  if_fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst),
    .pc_en   (pc_en),
    .next_pc (next_pc),
    .pc      (fetch_pc)
  );

  // Wraps modulo 2^32 by width truncation.
  assign fetch_pc4 = fetch_pc + 32'd4;

  if_fetch_stage_imem #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_imem (
    .clk     (clk),
    .rd_addr (fetch_pc),
    .rd_data (fetch_inst),
    .wr_en   (wb_en),
    .wr_addr (wb_address),
    .wr_data (wb_data)
  );

  assign ifid_d.pc   = fetch_pc;
  assign ifid_d.pc4  = fetch_pc4;
  assign ifid_d.inst = fetch_inst;
  assign ifid_d.pred = prediction_in;

  if_fetch_stage_ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst),
    .en    (ifid_en),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign pc_out          = ifid_q.pc;
  assign pc4_out         = ifid_q.pc4;
  assign instruction_out = ifid_q.inst;
  assign prediction_out  = ifid_q.pred;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a behavioural model pushes expected post-edge
// state for every driven cycle; the values are popped and compared after the edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_en = 1'b0, ifid_en = 1'b0, ifid_flush = 1'b0;
  logic [31:0] next_pc = '0;
  logic        prediction_in = 1'b0;
  logic        wb_en = 1'b0;
  logic [31:0] wb_address = '0, wb_data = '0;
  logic [31:0] fetch_pc, fetch_pc4, fetch_inst;
  logic [31:0] pc_out, pc4_out, instruction_out;
  logic        prediction_out;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .MEM_DEPTH (1024),
    .RESET_PC  (32'h0000_0000),
    .NOP_INST  (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .next_pc         (next_pc),
    .prediction_in   (prediction_in),
    .wb_en           (wb_en),
    .wb_address      (wb_address),
    .wb_data         (wb_data),
    .fetch_pc        (fetch_pc),
    .fetch_pc4       (fetch_pc4),
    .fetch_inst      (fetch_inst),
    .pc_out          (pc_out),
    .pc4_out         (pc4_out),
    .instruction_out (instruction_out),
    .prediction_out  (prediction_out)
  );

  typedef struct {
    logic [31:0] fpc, fpc4, finst, pc, pc4, inst;
    logic        pred;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_mem [1024];
  logic [31:0] m_pc;
  logic [31:0] m_ifpc, m_ifpc4, m_ifinst;
  logic        m_ifpred;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [9:0] i;
    i = a[11:2];
    return int'(i);
  endfunction

  task automatic model_reset();
    m_pc     = 32'h0;
    m_ifpc   = 32'h0;
    m_ifpc4  = 32'h0;
    m_ifinst = NOP;
    m_ifpred = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational read, then compare post-edge.
  task automatic step(input logic pe, input logic ie, input logic fl, input logic [31:0] npc,
                      input logic pr, input logic we, input logic [31:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] pre_inst;
    @(negedge clk);
    pc_en = pe; ifid_en = ie; ifid_flush = fl; next_pc = npc;
    prediction_in = pr; wb_en = we; wb_address = wa; wb_data = wd;
    #1;
    pre_inst = m_mem[widx(m_pc)];
    chk("pre_fetch_inst", fetch_inst, pre_inst);
    if (fl) begin
      m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ifinst = NOP; m_ifpred = 1'b0;
    end else if (ie) begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_ifinst = pre_inst; m_ifpred = pr;
    end
    if (pe) m_pc = npc;
    if (we) m_mem[widx(wa)] = wd;
    e.fpc = m_pc; e.fpc4 = m_pc + 32'd4; e.finst = m_mem[widx(m_pc)];
    e.pc = m_ifpc; e.pc4 = m_ifpc4; e.inst = m_ifinst; e.pred = m_ifpred;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("fetch_pc", fetch_pc, e.fpc);
    chk("fetch_pc4", fetch_pc4, e.fpc4);
    chk("fetch_inst", fetch_inst, e.finst);
    chk("pc_out", pc_out, e.pc);
    chk("pc4_out", pc4_out, e.pc4);
    chk("instruction_out", instruction_out, e.inst);
    chk("prediction_out", {31'b0, prediction_out}, {31'b0, e.pred});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, "_fetch_pc4"}, fetch_pc4, 32'h4);
    chk({tag, "_pc_out"}, pc_out, 32'h0);
    chk({tag, "_pc4_out"}, pc4_out, 32'h0);
    chk({tag, "_instruction_out"}, instruction_out, NOP);
    chk({tag, "_prediction_out"}, {31'b0, prediction_out}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
    model_reset();

    // Reset held
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;

    // Preload (PC held at 0, IF/ID held); 0x1014 wraps onto word 5
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_0000, 32'h1111_1111);
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_0004, 32'h0050_0093);
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_0008, 32'h00A0_0113);
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_000C, 32'h00F0_0193);
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_0010, 32'h0140_0213);
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_1014, 32'h0200_0293);
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_0FFC, 32'hDEAD_BEEF);
    // Write to the word being fetched: old data before the edge, new after
    step(0, 0, 0, 32'h0, 0, 1, 32'h0000_0000, 32'h0010_0013);
    chk("rw_same_word_new", fetch_inst, 32'h0010_0013);

    // Stream
    step(1, 1, 0, 32'h4, 0, 0, 32'h0, 32'h0);
    chk("stream_e1_fetch_inst", fetch_inst, 32'h0050_0093);
    step(1, 1, 0, 32'h8, 0, 0, 32'h0, 32'h0);
    chk("stream_e2_pc_out", pc_out, 32'h4);
    chk("stream_e2_pc4_out", pc4_out, 32'h8);
    chk("stream_e2_inst", instruction_out, 32'h0050_0093);
    step(1, 1, 0, 32'h8, 0, 0, 32'h0, 32'h0);
    chk("stream_e3_inst", instruction_out, 32'h00A0_0113);

    // Full stall while next_pc moves
    step(0, 0, 0, 32'hC, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'hC, 0, 0, 32'h0, 32'h0);
    chk("stall_fetch_pc", fetch_pc, 32'h8);

    // Resume; prediction bit follows the fetch at 0x10
    step(1, 1, 0, 32'hC, 0, 0, 32'h0, 32'h0);
    step(1, 1, 0, 32'h10, 0, 0, 32'h0, 32'h0);
    step(1, 1, 0, 32'h14, 1, 0, 32'h0, 32'h0);
    chk("pred_pc_out", pc_out, 32'h10);
    chk("pred_bit", {31'b0, prediction_out}, 32'h1);
    step(1, 1, 0, 32'h18, 0, 0, 32'h0, 32'h0);
    chk("pred_clear", {31'b0, prediction_out}, 32'h0);

    // PC stalled, IF/ID re-captures the same fetch
    step(0, 1, 0, 32'h40, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h40, 1, 0, 32'h0, 32'h0);

    // Flush beats enable, PC still advances; 0x1003 aliases word 0
    step(1, 1, 1, 32'h1003, 1, 0, 32'h0, 32'h0);
    chk("flush_inst", instruction_out, NOP);
    chk("flush_pc_out", pc_out, 32'h0);
    chk("wrap_fetch_inst", fetch_inst, 32'h0010_0013);
    step(1, 1, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0);
    chk("pc4_wrap", fetch_pc4, 32'h0);
    chk("top_word_inst", fetch_inst, 32'hDEAD_BEEF);
    step(1, 1, 0, 32'h14, 0, 0, 32'h0, 32'h0);
    step(1, 1, 0, 32'h8, 1, 0, 32'h0, 32'h0);

    // Mid-run reset: immediate, held across an edge, first edge after release loads next_pc
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    model_reset();
    rst = 1'b1;
    step(1, 1, 0, 32'h10, 0, 0, 32'h0, 32'h0);
    chk("post_rst_fetch_pc", fetch_pc, 32'h10);
    step(1, 1, 0, 32'h14, 1, 0, 32'h0, 32'h0);

    if (sb_q.size() != 0) chk("sb_drain", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
